uart_controller: RTL
====================

UART_CONTROLLER -- requirements
Module: uart_controller

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line baud rate.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 addr  in  32  bus byte address.
REQ-006 wdata  in  32  bus write data.
REQ-007 rd / wr  in  1 each  bus read / write strobes, one-cycle.
REQ-008 rdata  out  32  read data for the addressed register.
REQ-009 baud_tick  out  1  16x-oversample tick that clocks receiver and transmitter.
REQ-010 rx_en / tx_en  out  1 each  CON[1] / CON[0].
REQ-011 rx_data  in  8  receiver byte; rx_status  in  1  receiver byte-done flag (baud domain).
REQ-012 tx_data  out  8  byte to send; tx_start  out  1  send request; tx_status  in  1  transmitter busy.
REQ-013 irq  out  1  interrupt request.

Function
REQ-014 Register map: TXD 0x40000018 (W, [7:0]); RXD 0x4000001C (R, [7:0]); CON 0x40000020 (R/W).
REQ-015 CON bits: [0] tx_en RW; [1] rx_en RW; [2] tx_done sticky, RO; [3] rx_ready RO; [4] tx_busy RO; [5] overrun sticky, RO; [31:6] read 0.
REQ-016 rdata is combinational: addressed register zero-extended, 0 for unmapped addresses; CON writes affect only [1:0].
REQ-017 Read side effects occur in the rd cycle: CON read clears tx_done and overrun; RXD read consumes the current byte.
REQ-018 Divisor DIV = CLK_HZ/(BAUD*16), truncated (325 by default); baud_tick is high for 1 clk every DIV clks, counter 0..DIV-1, wrapping to 0.
REQ-019 rx_status passes through a 2-flop synchronizer; a rising edge on the synchronized signal while rx_en=1 captures rx_data.
REQ-020 TX FSM IDLE->START on a TXD write when tx_en=1 and in IDLE; latch wdata[7:0] into tx_data.
REQ-021 START: hold tx_start=1 until synchronized tx_status=1, then go to WAIT.
REQ-022 WAIT: when synchronized tx_status=0, set tx_done and go to IDLE.
REQ-023 tx_busy=1 in START and WAIT; a TXD write while busy or while tx_en=0 is ignored.
REQ-024 irq = rx_ready | tx_done.
REQ-025 Simultaneous set and clear of tx_done or overrun in one cycle: the set wins.

Reset
REQ-026 On reset low, asynchronously clear all state: TX FSM=IDLE, CON=0, tx_data=0, tx_start=0, baud counter=0, synchronizers=0, RX storage empty; rdata follows the cleared state.
REQ-027 Reset low mid-transfer abandons the byte; no tx_done is set after release.

Configuration
REQ-028 With UART_RX_FIFO_EN defined, RX storage is a 4-entry FIFO:
- rx_ready = not empty; RXD reads the head; an RXD read pops.
- A capture when full is dropped and sets overrun.
- A capture and a pop in the same cycle both take effect.
REQ-029 Without UART_RX_FIFO_EN, RX storage is a single holding register:
- A capture sets rx_ready; an RXD read clears it.
- A capture while rx_ready=1 overwrites the byte and sets overrun.
- A capture and a read in the same cycle: the read returns the old byte and rx_ready stays 1.

Structure
REQ-030 A shared package holds the three address constants, the CON bit indices, and the TX FSM state encoding.
REQ-031 The RX FIFO is sub-module uart_rx_fifo (depth parameter, default 4), instantiated only under UART_RX_FIFO_EN.

Verification
REQ-032 CLK_HZ=50000000, BAUD=9600 -> baud_tick pulses exactly every 325 clks, 1 clk wide.
REQ-033 Write CON=0x1, write TXD=0x55, model busy for 100 clks -> tx_data=0x55, tx_start until busy, CON[2]=1, irq=1; CON read -> CON[2]=0.
REQ-034 Write TXD=0xAA while busy -> tx_data unchanged, no second tx_start.
REQ-035 rx_en=1, receiver delivers 0x3C -> CON[3]=1; RXD read=0x3C; CON[3]=0 after the read.
REQ-036 Five bytes 0x01..0x05, no reads -> FIFO build: reads return 0x01..0x04, CON[5]=1; non-FIFO build: read returns 0x05, CON[5]=1.
REQ-037 Reset asserted in START -> tx_start=0 and CON=0 immediately; no irq after release.

Source files
------------

// File: rtl/uart_controller_pkg.sv
// Shared definitions for the UART controller: register addresses, CON bit
// positions, TX handshake state encoding and the baud divisor helper.
package uart_controller_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_EN    = 0;
    localparam int CON_RX_EN    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_READY = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVERRUN  = 5;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / (baud * 32'sd16);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; a push while full is dropped
// and a pop while empty is ignored, so the caller only has to flag overrun.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Pointer and occupancy next-state; simultaneous push and pop keep the count.
    always_comb begin
        do_push_s = push_i & (count_q != CNT_FULL);
        do_pop_s  = pop_i & (count_q != CNT_ZERO);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PW'(0) : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PW'(0) : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == CNT_ZERO);
    assign full_o  = (count_q == CNT_FULL);

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped UART controller: baud tick generator, TX start/busy handshake
// and RX byte storage. Define UART_RX_FIFO_EN for a 4-deep RX FIFO instead of
// the single holding register.
module uart_controller
    import uart_controller_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        baud_tick,
    output logic        rx_en,
    output logic        tx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_status,
    output logic        irq
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] baud_cnt_q;
    logic          baud_tick_q;
    logic [2:0]    rx_sync_q;
    logic [1:0]    tx_sync_q;
    logic [1:0]    con_q, con_d;
    logic          tx_done_q, tx_done_d, overrun_q, overrun_d;
    tx_state_e     state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q;
    logic          rd_con_s, rd_rxd_s, wr_con_s, wr_txd_s;
    logic          capture_s, tx_ack_s, tx_busy_s, tx_done_set_s;
    logic          rx_ready_s, rx_drop_s;
    logic [7:0]    rx_head_s;
    logic          unused_wdata_s;

    assign unused_wdata_s = ^wdata[31:8];
    assign rd_con_s  = rd & (addr == ADDR_CON);
    assign rd_rxd_s  = rd & (addr == ADDR_RXD);
    assign wr_con_s  = wr & (addr == ADDR_CON);
    assign wr_txd_s  = wr & (addr == ADDR_TXD);
    // Edge detect on the synchronized receiver flag, not the raw input.
    assign capture_s = rx_sync_q[1] & ~rx_sync_q[2] & con_q[CON_RX_EN];
    assign tx_ack_s  = tx_sync_q[1];
    assign tx_busy_s = (state_q != TX_IDLE);

`ifdef UART_RX_FIFO_EN
    logic fifo_empty_s, fifo_full_s;

    uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (capture_s),
        .pop_i   (rd_rxd_s),
        .data_i  (rx_data),
        .data_o  (rx_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    assign rx_ready_s = ~fifo_empty_s;
    assign rx_drop_s  = capture_s & fifo_full_s;
`else
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_ready_q, rx_ready_d;

    // A capture beats a same-cycle read, so the flag stays set for the new byte.
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_ready_d = rx_ready_q;
        if (capture_s) begin
            rx_byte_d  = rx_data;
            rx_ready_d = 1'b1;
        end else if (rd_rxd_s) begin
            rx_ready_d = 1'b0;
        end else begin
            rx_ready_d = rx_ready_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_byte_q  <= 8'h00;
            rx_ready_q <= 1'b0;
        end else begin
            rx_byte_q  <= rx_byte_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign rx_head_s  = rx_byte_q;
    assign rx_ready_s = rx_ready_q;
    assign rx_drop_s  = capture_s & rx_ready_q & ~rd_rxd_s;
`endif

    // TX handshake: request until the transmitter reports busy, done when it drops.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_done_set_s = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (wr_txd_s && con_q[CON_TX_EN]) begin
                    state_d   = TX_START;
                    tx_data_d = wdata[7:0];
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_ack_s) begin
                    state_d = TX_WAIT;
                end else begin
                    state_d = TX_START;
                end
            end
            TX_WAIT: begin
                if (!tx_ack_s) begin
                    state_d       = TX_IDLE;
                    tx_done_set_s = 1'b1;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Control bits and sticky flags; a set in the same cycle as a CON read wins.
    always_comb begin
        con_d     = wr_con_s ? wdata[1:0] : con_q;
        tx_done_d = tx_done_q;
        overrun_d = overrun_q;
        if (tx_done_set_s) begin
            tx_done_d = 1'b1;
        end else if (rd_con_s) begin
            tx_done_d = 1'b0;
        end else begin
            tx_done_d = tx_done_q;
        end
        if (rx_drop_s) begin
            overrun_d = 1'b1;
        end else if (rd_con_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // All controller state, including baud divider and synchronizers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_q  <= CW'(0);
            baud_tick_q <= 1'b0;
            rx_sync_q   <= 3'b000;
            tx_sync_q   <= 2'b00;
            con_q       <= 2'b00;
            tx_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
            state_q     <= TX_IDLE;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
        end else begin
            baud_cnt_q  <= (baud_cnt_q == CNT_LAST) ? CW'(0) : baud_cnt_q + CW'(1);
            baud_tick_q <= (baud_cnt_q == CNT_LAST);
            rx_sync_q   <= {rx_sync_q[1:0], rx_status};
            tx_sync_q   <= {tx_sync_q[0], tx_status};
            con_q       <= con_d;
            tx_done_q   <= tx_done_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= (state_d == TX_START);
        end
    end

    // Bus read mux.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            ADDR_RXD: rdata = {24'h00_0000, rx_head_s};
            ADDR_CON: rdata = {26'h000_0000, overrun_q, tx_busy_s, rx_ready_s, tx_done_q, con_q};
            default:  rdata = 32'h0000_0000;
        endcase
    end

    assign baud_tick = baud_tick_q;
    assign tx_en     = con_q[CON_TX_EN];
    assign rx_en     = con_q[CON_RX_EN];
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign irq       = rx_ready_s | tx_done_q;

endmodule
